// File: rtl/qam_sym_packer.sv
// qam_sym_packer
//   Converts a framed byte stream into 4-bit symbols for the 16-QAM modulator.
//   Each frame starts with an alternating preamble (PRE_SYM, ~PRE_SYM, ...).
//   After the preamble, each byte is sent as two nibbles, MS nibble first.
//
// Ports
//   axi_clk    clock, rising edge
//   axi_rst    synchronous active-high reset
//   s_valid    byte input handshake: valid
//   s_data     byte input: data
//   s_last     byte input: last byte of frame
//   s_ready    byte input handshake: ready
//   sym_valid  symbol output: valid
//   sym_data   symbol output: data
//   sym_ready  symbol output: downstream ready
//   sym_sof    high with the first preamble symbol of each frame
//   busy       high whenever the packer is not idle
//   frame_cnt  completed frames, wraps at all-ones
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for the first byte of a frame, buffer empty
// ST_PRE   | emitting preamble symbols, first byte held in buffer
// ST_DATA  | emitting nibbles of buffered bytes, refilling as they drain

module qam_sym_packer #(
   parameter int           PREAMBLE_LEN = 8,
   parameter logic [3:0]   PRE_SYM      = 4'h3,
   parameter int           CNT_WIDTH    = 16
) (
   input  logic                 axi_clk,
   input  logic                 axi_rst,
   input  logic                 s_valid,
   input  logic [7:0]           s_data,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic                 sym_valid,
   output logic [3:0]           sym_data,
   input  logic                 sym_ready,
   output logic                 sym_sof,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] frame_cnt
);

   localparam int PCW = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PCW-1:0] PRE_LAST = PCW'(PREAMBLE_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           buf_data_q, buf_data_d;
   logic                 buf_last_q, buf_last_d;
   logic                 buf_full_q, buf_full_d;
   logic                 nib_sel_q, nib_sel_d;
   logic [PCW-1:0]       pre_cnt_q, pre_cnt_d;
   logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

   logic       s_ready_w;
   logic       sym_valid_w;
   logic [3:0] sym_data_w;
   logic       sym_sof_w;
   logic       s_hs;
   logic       sym_hs;

   // Output decode from registered state. s_ready in ST_DATA looks at
   // sym_ready so a byte can be refilled in the same cycle the last
   // nibble of the previous byte leaves, keeping the stream bubble-free.
   always_comb begin
      s_ready_w   = 1'b0;
      sym_valid_w = 1'b0;
      sym_data_w  = 4'h0;
      sym_sof_w   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            s_ready_w = 1'b1;
         end
         ST_PRE: begin
            sym_valid_w = 1'b1;
            sym_data_w  = pre_cnt_q[0] ? ~PRE_SYM : PRE_SYM;
            sym_sof_w   = (pre_cnt_q == '0);
         end
         ST_DATA: begin
            sym_valid_w = buf_full_q;
            sym_data_w  = nib_sel_q ? buf_data_q[3:0] : buf_data_q[7:4];
            s_ready_w   = !buf_full_q || (nib_sel_q && sym_ready && !buf_last_q);
         end
         default: begin
            s_ready_w = 1'b0;
         end
      endcase
   end

   assign s_hs   = s_valid && s_ready_w;
   assign sym_hs = sym_valid_w && sym_ready;

   always_comb begin
      state_d     = state_q;
      buf_data_d  = buf_data_q;
      buf_last_d  = buf_last_q;
      buf_full_d  = buf_full_q;
      nib_sel_d   = nib_sel_q;
      pre_cnt_d   = pre_cnt_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (s_hs) begin
               buf_data_d = s_data;
               buf_last_d = s_last;
               buf_full_d = 1'b1;
               pre_cnt_d  = '0;
               state_d    = ST_PRE;
            end
         end
         ST_PRE: begin
            if (sym_hs) begin
               pre_cnt_d = pre_cnt_q + PCW'(1);
               if (pre_cnt_q == PRE_LAST) begin
                  nib_sel_d = 1'b0;
                  state_d   = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (sym_hs) begin
               if (!nib_sel_q) begin
                  nib_sel_d = 1'b1;
               end else if (buf_last_q) begin
                  nib_sel_d   = 1'b0;
                  buf_full_d  = 1'b0;
                  frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                  state_d     = ST_IDLE;
               end else begin
                  nib_sel_d = 1'b0;
                  if (s_hs) begin
                     buf_data_d = s_data;
                     buf_last_d = s_last;
                  end else begin
                     buf_full_d = 1'b0;
                  end
               end
            end else if (s_hs) begin
               // buffer was empty (input gap): refill, start at MS nibble
               buf_data_d = s_data;
               buf_last_d = s_last;
               buf_full_d = 1'b1;
               nib_sel_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         state_q     <= ST_IDLE;
         buf_data_q  <= 8'h00;
         buf_last_q  <= 1'b0;
         buf_full_q  <= 1'b0;
         nib_sel_q   <= 1'b0;
         pre_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         buf_data_q  <= buf_data_d;
         buf_last_q  <= buf_last_d;
         buf_full_q  <= buf_full_d;
         nib_sel_q   <= nib_sel_d;
         pre_cnt_q   <= pre_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Handshake outputs are forced quiet while reset is held, even if the
   // state registers still hold a mid-frame state.
   assign s_ready   = s_ready_w   && !axi_rst;
   assign sym_valid = sym_valid_w && !axi_rst;
   assign sym_sof   = sym_sof_w   && !axi_rst;
   assign sym_data  = sym_data_w;
   assign busy      = (state_q != ST_IDLE) && !axi_rst;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_qam_sym_packer.sv
module tb_qam_sym_packer;

   logic        axi_clk;
   logic        axi_rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic        sym_valid;
   logic [3:0]  sym_data;
   logic        sym_ready;
   logic        sym_sof;
   logic        busy;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   qam_sym_packer dut (
      .axi_clk   (axi_clk),
      .axi_rst   (axi_rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_ready (sym_ready),
      .sym_sof   (sym_sof),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   initial begin
      axi_clk = 1'b0;
      forever #5 axi_clk = ~axi_clk;
   end

   int cyc = 0;
   always @(posedge axi_clk) cyc <= cyc + 1;

   // downstream ready: constant 1 or random 50 %
   bit rand_rdy = 1'b0;
   initial begin
      sym_ready = 1'b1;
      forever begin
         @(posedge axi_clk);
         #1;
         sym_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // observed symbol stream and stall stability
   logic [3:0] obs_q[$];
   bit         obs_sof_q[$];
   int         obs_cyc_q[$];
   int         stall_err = 0;
   bit         prev_stall = 1'b0;
   logic [3:0] prev_data = 4'h0;

   always @(negedge axi_clk) begin
      if (!axi_rst) begin
         if (prev_stall && !(sym_valid && sym_data === prev_data))
            stall_err++;
         if (sym_valid && sym_ready) begin
            obs_q.push_back(sym_data);
            obs_sof_q.push_back(sym_sof);
            obs_cyc_q.push_back(cyc);
         end
         prev_stall = sym_valid && !sym_ready;
         prev_data  = sym_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // reference model: expected symbol list built from frame contents
   logic [3:0] exp_q[$];
   bit         exp_sof_q[$];

   task automatic model_frame(input logic [7:0] bytes[$]);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back((i % 2 == 1) ? 4'hC : 4'h3);
         exp_sof_q.push_back(i == 0);
      end
      foreach (bytes[i]) begin
         exp_q.push_back(bytes[i] / 16);
         exp_sof_q.push_back(1'b0);
         exp_q.push_back(bytes[i] % 16);
         exp_sof_q.push_back(1'b0);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      obs_q.delete();
      obs_sof_q.delete();
      obs_cyc_q.delete();
      exp_q.delete();
      exp_sof_q.delete();
   endtask

   task automatic compare_all(input string tag);
      int w = 0;
      int n;
      while (obs_q.size() < exp_q.size() && w < 3000) begin
         @(negedge axi_clk);
         #1;
         w++;
      end
      repeat (3) @(negedge axi_clk);
      #1;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_sym%0d", tag, i), obs_q[i], exp_q[i]);
         chk($sformatf("%s_sof%0d", tag, i), obs_sof_q[i], exp_sof_q[i]);
      end
   endtask

   int acc_cyc;
   int first_acc;

   // entry and exit: 1 time unit after a rising edge
   task automatic send_byte(input logic [7:0] d, input logic l);
      int w = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge axi_clk);
      while (!s_ready && w < 3000) begin
         @(negedge axi_clk);
         w++;
      end
      if (!s_ready) chk("s_ready_timeout", 0, 1);
      acc_cyc = cyc;
      @(posedge axi_clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] bytes[$], input int gap, input bit chk_gap);
      foreach (bytes[i]) begin
         send_byte(bytes[i], i == bytes.size() - 1);
         if (i == 0) first_acc = acc_cyc;
         if (gap > 0 && i != bytes.size() - 1) begin
            idle_inputs();
            for (int g = 0; g < gap; g++) begin
               @(negedge axi_clk);
               if (chk_gap && i >= 1 && g == gap - 1) chk("gap_valid", sym_valid, 0);
               @(posedge axi_clk);
               #1;
            end
         end
      end
      idle_inputs();
   endtask

   task automatic do_reset();
      axi_rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge axi_clk);
      #1;
      axi_rst = 1'b0;
      clear_q();
   endtask

   initial begin
      logic [7:0] fr[$];
      axi_rst = 1'b1;
      idle_inputs();

      // reset state
      @(negedge axi_clk);
      chk("rst_sym_valid", sym_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sof", sym_sof, 0);
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b0;
      @(negedge axi_clk);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("idle_s_ready", s_ready, 1);
      chk("idle_busy", busy, 0);
      @(posedge axi_clk);
      #1;
      clear_q();

      // T1 single frame
      fr = {8'hA5};
      model_frame(fr);
      send_frame(fr, 0, 0);
      compare_all("t1");
      if (obs_cyc_q.size() == 10) begin
         chk("t1_latency", obs_cyc_q[0], first_acc + 1);
         chk("t1_contig", obs_cyc_q[9] - obs_cyc_q[0], 9);
      end else chk("t1_len", obs_cyc_q.size(), 10);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_s_ready", s_ready, 1);
      chk("t1_busy", busy, 0);

      // T2 full rate
      do_reset();
      fr = {8'h01, 8'h23, 8'h45, 8'h67};
      model_frame(fr);
      send_frame(fr, 0, 0);
      compare_all("t2");
      if (obs_cyc_q.size() == 16)
         chk("t2_contig", obs_cyc_q[15] - obs_cyc_q[0], 15);
      else chk("t2_len", obs_cyc_q.size(), 16);
      chk("t2_frame_cnt", frame_cnt, 1);

      // T3 backpressure with random data
      do_reset();
      fr.delete();
      for (int i = 0; i < 16; i++) fr.push_back(8'($urandom));
      model_frame(fr);
      stall_err = 0;
      rand_rdy = 1'b1;
      send_frame(fr, 0, 0);
      compare_all("t3");
      rand_rdy = 1'b0;
      chk("t3_stall_stable", stall_err, 0);
      chk("t3_frame_cnt", frame_cnt, 1);

      // T4 input gaps
      do_reset();
      fr.delete();
      for (int i = 0; i < 3; i++) fr.push_back(8'($urandom));
      model_frame(fr);
      send_frame(fr, 5, 1);
      compare_all("t4");
      chk("t4_frame_cnt", frame_cnt, 1);

      // T5 reset mid-frame after the 3rd data symbol
      do_reset();
      fr = {8'h12, 8'h34};
      model_frame(fr);
      void'(exp_q.pop_back());
      void'(exp_sof_q.pop_back());
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      idle_inputs();
      begin
         int w = 0;
         while (obs_q.size() < 11 && w < 3000) begin
            @(negedge axi_clk);
            #1;
            w++;
         end
      end
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b1;
      @(negedge axi_clk);
      chk("t5_valid_in_rst", sym_valid, 0);
      chk("t5_s_ready_in_rst", s_ready, 0);
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b0;
      @(negedge axi_clk);
      chk("t5_valid_after", sym_valid, 0);
      chk("t5_frame_cnt", frame_cnt, 0);
      chk("t5_busy", busy, 0);
      compare_all("t5a");
      clear_q();
      @(posedge axi_clk);
      #1;
      fr = {8'h9B};
      model_frame(fr);
      send_frame(fr, 0, 0);
      compare_all("t5b");
      chk("t5_frame_cnt2", frame_cnt, 1);

      // T6 back-to-back single-byte frames
      do_reset();
      fr = {8'h5A};
      model_frame(fr);
      fr = {8'hC3};
      model_frame(fr);
      send_byte(8'h5A, 1'b1);
      send_byte(8'hC3, 1'b1);
      idle_inputs();
      compare_all("t6");
      if (obs_cyc_q.size() == 20) begin
         chk("t6_bubble", obs_cyc_q[10] - obs_cyc_q[9], 2);
         chk("t6_contig1", obs_cyc_q[9] - obs_cyc_q[0], 9);
      end else chk("t6_len", obs_cyc_q.size(), 20);
      chk("t6_frame_cnt", frame_cnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
